regfile_2r1w_clr: RTL and testbench
===================================

REGFILE_2R1W_CLR -- requirements
Module: regfile_2r1w_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of each register entry in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning the address width; depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning that when 1, entry 0 always reads 0 and writes to it are discarded.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port we, input, 1 bit: write enable.
REQ-007 SHALL have port write_addr, input, ADDR_WIDTH bits: write address.
REQ-008 SHALL have port data_i, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port rs1_addr, input, ADDR_WIDTH bits: read port 1 address.
REQ-010 SHALL have port rs2_addr, input, ADDR_WIDTH bits: read port 2 address.
REQ-011 SHALL have port rs1_data_o, output, DATA_WIDTH bits: read port 1 data.
REQ-012 SHALL have port rs2_data_o, output, DATA_WIDTH bits: read port 2 data.
REQ-013 SHALL have port busy_o, output, 1 bit: high while the clear sweep is in progress.

Function
REQ-014 SHALL implement the storage as an unreset DEPTH x DATA_WIDTH array with one write port and two independent asynchronous (combinational) read ports.
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR, SHALL write 0 to entry clr_cnt every cycle, where clr_cnt is an ADDR_WIDTH-bit counter starting at 0 and incrementing by 1 per cycle.
REQ-017 SHALL transition CLEAR -> READY on the edge that clears entry DEPTH-1; the sweep therefore takes exactly DEPTH cycles after rst deasserts, with no counter wrap-around.
REQ-018 SHALL remain in READY until rst is asserted; READY has no other exit.
REQ-019 In CLEAR, SHALL ignore we; external writes are dropped and not queued.
REQ-020 In CLEAR, SHALL drive both rs1_data_o and rs2_data_o to 0 regardless of address.
REQ-021 In READY, SHALL write data_i to entry write_addr on the rising edge when we=1, except when ZERO_REG=1 and write_addr=0.
REQ-022 In READY, SHALL drive rsN_data_o = entry[rsN_addr] with zero cycles of latency, and SHALL drive 0 when ZERO_REG=1 and rsN_addr=0.
REQ-023 SHALL drive busy_o = 1 in CLEAR and 0 in READY.
REQ-024 When both read addresses are equal, SHALL return identical data on both ports.

Reset
REQ-025 When rst=1 at a rising edge, SHALL enter CLEAR with clr_cnt=0, including when rst is asserted mid-sweep (the sweep restarts from 0) and when it is asserted in READY.
REQ-026 While rst=1, SHALL hold busy_o=1 and rs1_data_o=rs2_data_o=0, and SHALL perform no array write.
REQ-027 When rst=1 and we=1 in the same cycle, SHALL let reset win and discard the write.

Configuration
REQ-028 SHALL use macro REGFILE_BYPASS_EN; when it is defined, in READY with we=1 and rsN_addr=write_addr (excluding register 0 when ZERO_REG=1), rsN_data_o SHALL equal data_i in the same cycle.
REQ-029 When REGFILE_BYPASS_EN is undefined, a same-cycle read of the entry being written SHALL return the old contents, and the new value SHALL become visible from the next cycle.

Verification
REQ-030 Bench SHALL cover: rst=1 for 1 cycle, then deassert with defaults -> busy_o=1 for exactly 32 cycles then 0, and every entry reads 0.
REQ-031 Bench SHALL cover: READY; write 0xDEADBEEF to entry 5, then rs1_addr=rs2_addr=5 -> both ports return 0xDEADBEEF the next cycle.
REQ-032 Bench SHALL cover: READY; we=1, write_addr=0, data_i=0xFFFFFFFF, with ZERO_REG=1 -> rs1_data_o for address 0 stays 0.
REQ-033 Bench SHALL cover: write 0x12345678 to entry 7 with rs2_addr=7 in the same cycle, where entry 7 holds 0x1 -> same cycle returns 0x12345678 with REGFILE_BYPASS_EN and 0x1 without it.
REQ-034 Bench SHALL cover: rst pulse at sweep cycle 10, then we=1, addr 3, data 0xA5 during CLEAR -> sweep restarts, busy_o=1 for a further 32 cycles, and entry 3 reads 0 afterwards.
REQ-035 Bench SHALL cover: ADDR_WIDTH=3, DATA_WIDTH=16 -> busy_o=1 for 8 cycles, and writes to entries 1..7 read back correctly.

Source files
------------

// File: rtl/regfile_2r1w_clr.sv
// 2-read/1-write register file that sweeps every entry to zero after reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.

module regfile_2r1w_clr_rd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] mem,
  input  logic [ADDR_WIDTH-1:0]                    addr,
  input  logic                                     blank,
  input  logic                                     byp_vld,
  input  logic [ADDR_WIDTH-1:0]                    byp_addr,
  input  logic [DATA_WIDTH-1:0]                    byp_data,
  output logic [DATA_WIDTH-1:0]                    data
);
  always_comb begin
    data = mem[addr];
    if (blank || ((ZERO_REG != 0) && (addr == '0)))
      data = '0;
    else if (byp_vld && (addr == byp_addr))
      data = byp_data;
  end
endmodule

module regfile_2r1w_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic                  busy_o
);
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                               state;
  logic [ADDR_WIDTH-1:0]                clr_cnt;
  logic                                 busy_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem;
  logic                                 wr_en;
  logic [ADDR_WIDTH-1:0]                wr_addr;
  logic [DATA_WIDTH-1:0]                wr_data;
  logic                                 ext_wr;
  logic                                 byp_vld;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state  <= READY;
            busy_q <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // rst is folded in so reads and busy respond in the cycle rst is raised,
  // not only after the edge that samples it.
  assign busy_o = busy_q | rst;
  assign ext_wr = !rst && (state == READY) && we &&
                  !((ZERO_REG != 0) && (write_addr == '0));

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_addr;
    wr_data = data_i;
    if (!rst && (state == CLEAR)) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = '0;
    end else if (ext_wr) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_vld = ext_wr;
`else
  assign byp_vld = 1'b0;
`endif

  assign rd_addr = {rs2_addr, rs1_addr};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_2r1w_clr_rd #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .mem      (mem),
      .addr     (rd_addr[g]),
      .blank    (busy_o),
      .byp_vld  (byp_vld),
      .byp_addr (write_addr),
      .byp_data (data_i),
      .data     (rd_data[g])
    );
  end

  assign rs1_data_o = rd_data[0];
  assign rs2_data_o = rd_data[1];
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed bench for regfile_2r1w_clr: default 32x32 instance plus an 8x16 instance.
module tb_regfile_2r1w_clr;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  write_addr, rs1_addr, rs2_addr;
  logic [31:0] data_i, rs1_data_o, rs2_data_o;
  logic        busy_o;

  logic        s_rst, s_we;
  logic [2:0]  s_waddr, s_ra1, s_ra2;
  logic [15:0] s_data, s_rd1, s_rd2;
  logic        s_busy;

  int total = 0;
  int passed = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_2r1w_clr dut (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .data_i(data_i),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .busy_o(busy_o)
  );

  regfile_2r1w_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
    .clk(clk), .rst(s_rst), .we(s_we), .write_addr(s_waddr), .data_i(s_data),
    .rs1_addr(s_ra1), .rs2_addr(s_ra2),
    .rs1_data_o(s_rd1), .rs2_data_o(s_rd2), .busy_o(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; write_addr = '0; data_i = '0; rs1_addr = 5'd3; rs2_addr = 5'd9;
    s_rst = 1'b1; s_we = 1'b0; s_waddr = '0; s_data = '0; s_ra1 = '0; s_ra2 = '0;
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd1);
    chk("rst_rs1", rs1_data_o, 32'd0);
    chk("rst_rs2", rs2_data_o, 32'd0);

    // Sweep length after a one-cycle reset
    rst = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 100) begin
      if (cnt == 5) chk("clear_rs1_zero", rs1_data_o, 32'd0);
      cnt++;
      tick();
    end
    chk("sweep_len", cnt, 32'd32);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      chk("init_rs1", rs1_data_o, 32'd0);
      chk("init_rs2", rs2_data_o, 32'd0);
    end

    // Write then read both ports at the same address
    we = 1'b1; write_addr = 5'd5; data_i = 32'hDEADBEEF; rs1_addr = 5'd5; rs2_addr = 5'd5;
    tick();
    we = 1'b0;
    #1;
    chk("wr5_rs1", rs1_data_o, 32'hDEADBEEF);
    chk("wr5_rs2", rs2_data_o, 32'hDEADBEEF);

    // Zero register discards writes
    we = 1'b1; write_addr = 5'd0; data_i = 32'hFFFFFFFF; rs1_addr = 5'd0;
    #1;
    chk("zero_same", rs1_data_o, 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("zero_after", rs1_data_o, 32'd0);

    // Same-cycle read of the entry being written
    we = 1'b1; write_addr = 5'd7; data_i = 32'h1;
    tick();
    data_i = 32'h12345678; rs2_addr = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr7_same", rs2_data_o, 32'h12345678);
`else
    chk("wr7_same", rs2_data_o, 32'h1);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("wr7_next", rs2_data_o, 32'h12345678);

    // Reset from READY blanks outputs immediately
    rs1_addr = 5'd5;
    rst = 1'b1;
    #1;
    chk("ready_rst_busy", {31'd0, busy_o}, 32'd1);
    chk("ready_rst_rs1", rs1_data_o, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_sweep_busy", {31'd0, busy_o}, 32'd1);

    // Reset pulse mid-sweep with a write that must lose to reset
    rst = 1'b1; we = 1'b1; write_addr = 5'd3; data_i = 32'hA5;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 100) begin
      cnt++;
      tick();
    end
    we = 1'b0;
    chk("restart_len", cnt, 32'd32);
    rs1_addr = 5'd3; rs2_addr = 5'd5;
    #1;
    chk("e3_zero", rs1_data_o, 32'd0);
    chk("e5_cleared", rs2_data_o, 32'd0);

    // Small configuration: 8 entries of 16 bits
    s_rst = 1'b0;
    cnt = 0;
    while (s_busy && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("s_sweep_len", cnt, 32'd8);
    s_we = 1'b1;
    for (int i = 1; i < 8; i++) begin
      s_waddr = 3'(i); s_data = 16'(16'h1000 + i * 16'h0111);
      tick();
    end
    s_we = 1'b0;
    for (int i = 1; i < 8; i++) begin
      s_ra1 = 3'(i); s_ra2 = 3'(i);
      #1;
      chk("s_rd1", {16'd0, s_rd1}, 32'(16'h1000 + i * 16'h0111));
      chk("s_rd2", {16'd0, s_rd2}, 32'(16'h1000 + i * 16'h0111));
    end
    s_ra1 = 3'd0;
    #1;
    chk("s_zero", {16'd0, s_rd1}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
